// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared constants, types and helpers for the SDRAM request arbiter.
//   - Field layout of the 41-bit single command word and the 32-bit burst
//     command word written into the SDRAM controller's command FIFOs.
//   - Return-path FSM state type.
//   - pack_single_cmd(): builds a single command word from its fields.
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int ADDR_W       = 24;
  localparam int DATA_W       = 16;
  localparam int CMD_W        = 41;
  localparam int CMD_WE_BIT   = 40;
  localparam int CMD_ADDR_MSB = 39;
  localparam int CMD_ADDR_LSB = 16;
  localparam int BURST_CMD_W  = 32;
  localparam int BURST_WORDS  = 8;
  localparam int BURST_DATA_W = BURST_WORDS * DATA_W;

  typedef enum logic {
    R_IDLE,
    R_POP
  } ret_state_t;

  // Reads carry a zero data field so the controller never sees stale data.
  function automatic logic [CMD_W-1:0] pack_single_cmd(
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [CMD_W-1:0] cmd;
    cmd                            = '0;
    cmd[CMD_WE_BIT]                = we;
    cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    cmd[DATA_W-1:0]                = we ? data : '0;
    return cmd;
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// ---------------------------------------------------------------------------
// sdram_tag_fifo
// Small synchronous show-ahead FIFO holding requester IDs of outstanding
// reads, so returned data can be routed back in issue order.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, d        write an entry (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   q              head entry, valid whenever empty is low
//   full, empty    occupancy flags
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module sdram_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign q       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= d;
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter
// Round-robin arbiter sharing one SDRAM controller between NUM_REQ
// requesters. Accepted commands are registered and written into the
// controller's single or burst command FIFO one cycle later. Read data
// coming back from the controller is routed to the issuing requester using
// one in-order tag queue per return path.
// Ports:
//   clk, rst_n_i            clock, asynchronous active-low reset
//   req_valid_i/ready_o     per-requester handshake (ready is one-hot)
//   req_we_i, req_burst_i   command kind (burst overrides we)
//   req_addr_i, req_data_i  packed per-requester address / write data
//   rsp_valid_o, rsp_data_o             single-read response strobe + data
//   rsp_burst_valid_o, rsp_burst_data_o burst response strobe + data
//   cmd_d_o/cmd_enq_o/cmd_alm_full_i        single command FIFO writer
//   burst_d_o/burst_enq_o/burst_alm_full_i  burst command FIFO writer
//   data_q_i/data_deq_o/data_empty_i        single data FIFO reader
//   burst_q_i/burst_deq_o/burst_empty_i     burst data FIFO reader
//   orphan_o                sticky: data arrived with no matching tag
// ---------------------------------------------------------------------------
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 3,
  parameter int  TAG_DEPTH = 16,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ-1:0]        req_burst_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [NUM_REQ-1:0]        rsp_burst_valid_o,
  output logic [BURST_DATA_W-1:0]   rsp_burst_data_o,
  output logic [CMD_W-1:0]          cmd_d_o,
  output logic                      cmd_enq_o,
  input  logic                      cmd_alm_full_i,
  output logic [BURST_CMD_W-1:0]    burst_d_o,
  output logic                      burst_enq_o,
  input  logic                      burst_alm_full_i,
  input  logic [DATA_W-1:0]         data_q_i,
  output logic                      data_deq_o,
  input  logic                      data_empty_i,
  input  logic [BURST_DATA_W-1:0]   burst_q_i,
  output logic                      burst_deq_o,
  input  logic                      burst_empty_i,
  output logic                      orphan_o
);

  logic [IDW-1:0]     rr_q;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW:0]       cand;
  logic [IDW-1:0]     rr_next;
  logic               accept;

  logic               sel_we;
  logic               sel_burst;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               stag_push;
  logic               stag_pop;
  logic [IDW-1:0]     stag_head;
  logic               stag_full;
  logic               stag_empty;
  logic               btag_push;
  logic               btag_pop;
  logic [IDW-1:0]     btag_head;
  logic               btag_full;
  logic               btag_empty;

  ret_state_t         s_state;
  ret_state_t         s_state_nxt;
  logic [DATA_W-1:0]  s_data_q;
  logic [IDW-1:0]     s_tag_q;
  logic               s_orphan;

  ret_state_t         b_state;
  ret_state_t         b_state_nxt;
  logic [BURST_DATA_W-1:0] b_data_q;
  logic [IDW-1:0]     b_tag_q;
  logic               b_orphan;

  // A requester only competes when its target path can take the command,
  // so a stalled path never blocks traffic headed for the other one.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_burst_i[i]) begin
        eligible[i] = req_valid_i[i] && !burst_alm_full_i && !btag_full;
      end else if (req_we_i[i]) begin
        eligible[i] = req_valid_i[i] && !cmd_alm_full_i;
      end else begin
        eligible[i] = req_valid_i[i] && !cmd_alm_full_i && !stag_full;
      end
    end
  end

  // Scan eligible requesters starting at rr_q, wrapping at NUM_REQ; the
  // first hit wins. cand has one spare bit so rr_q + k never overflows.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!grant_found && eligible[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Reset gates the grant so nothing is accepted while reset is asserted.
  assign accept  = grant_found && rst_n_i;
  assign rr_next = (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  assign sel_we    = req_we_i[grant_idx];
  assign sel_burst = req_burst_i[grant_idx];
  assign sel_addr  = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data_i[grant_idx*DATA_W +: DATA_W];

  assign stag_push = accept && !sel_burst && !sel_we;
  assign btag_push = accept && sel_burst;

  // Command register: the accepted command is presented to the controller
  // one cycle after the handshake, with a single-cycle enqueue strobe.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q        <= '0;
      cmd_enq_o   <= 1'b0;
      cmd_d_o     <= '0;
      burst_enq_o <= 1'b0;
      burst_d_o   <= '0;
    end else begin
      cmd_enq_o   <= accept && !sel_burst;
      burst_enq_o <= accept && sel_burst;
      if (accept) rr_q <= rr_next;
      if (accept && !sel_burst) cmd_d_o <= pack_single_cmd(sel_we, sel_addr, sel_data);
      if (accept && sel_burst) burst_d_o <= {{(BURST_CMD_W-ADDR_W){1'b0}}, sel_addr};
    end
  end

  sdram_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (TAG_DEPTH)
  ) u_single_tags (
    .clk   (clk),
    .rst_n (rst_n_i),
    .push  (stag_push),
    .pop   (stag_pop),
    .d     (grant_idx),
    .q     (stag_head),
    .full  (stag_full),
    .empty (stag_empty)
  );

  sdram_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (TAG_DEPTH)
  ) u_burst_tags (
    .clk   (clk),
    .rst_n (rst_n_i),
    .push  (btag_push),
    .pop   (btag_pop),
    .d     (grant_idx),
    .q     (btag_head),
    .full  (btag_full),
    .empty (btag_empty)
  );

  // Single return path: take the FIFO head together with the oldest tag,
  // then strobe the owner's response in the following cycle. Data with no
  // tag behind it (e.g. after a reset) is drained and flagged as orphan.
  always_comb begin
    s_state_nxt = s_state;
    data_deq_o  = 1'b0;
    stag_pop    = 1'b0;
    s_orphan    = 1'b0;
    unique case (s_state)
      R_IDLE: begin
        if (rst_n_i && !data_empty_i) begin
          data_deq_o = 1'b1;
          if (!stag_empty) begin
            stag_pop    = 1'b1;
            s_state_nxt = R_POP;
          end else begin
            s_orphan = 1'b1;
          end
        end
      end
      R_POP:   s_state_nxt = R_IDLE;
      default: s_state_nxt = R_IDLE;
    endcase
  end

  // Burst return path, same behaviour as the single path.
  always_comb begin
    b_state_nxt = b_state;
    burst_deq_o = 1'b0;
    btag_pop    = 1'b0;
    b_orphan    = 1'b0;
    unique case (b_state)
      R_IDLE: begin
        if (rst_n_i && !burst_empty_i) begin
          burst_deq_o = 1'b1;
          if (!btag_empty) begin
            btag_pop    = 1'b1;
            b_state_nxt = R_POP;
          end else begin
            b_orphan = 1'b1;
          end
        end
      end
      R_POP:   b_state_nxt = R_IDLE;
      default: b_state_nxt = R_IDLE;
    endcase
  end

  // Return path state, captured data/tag, and the sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_state  <= R_IDLE;
      s_data_q <= '0;
      s_tag_q  <= '0;
      b_state  <= R_IDLE;
      b_data_q <= '0;
      b_tag_q  <= '0;
      orphan_o <= 1'b0;
    end else begin
      s_state  <= s_state_nxt;
      b_state  <= b_state_nxt;
      orphan_o <= orphan_o | s_orphan | b_orphan;
      if (stag_pop) begin
        s_data_q <= data_q_i;
        s_tag_q  <= stag_head;
      end
      if (btag_pop) begin
        b_data_q <= burst_q_i;
        b_tag_q  <= btag_head;
      end
    end
  end

  always_comb begin
    rsp_valid_o       = '0;
    rsp_burst_valid_o = '0;
    if (s_state == R_POP) rsp_valid_o[s_tag_q] = 1'b1;
    if (b_state == R_POP) rsp_burst_valid_o[b_tag_q] = 1'b1;
  end

  assign rsp_data_o       = s_data_q;
  assign rsp_burst_data_o = b_data_q;

endmodule
